// File: rtl/signal_tracker_query_arbiter_if.sv
// Bundle of requester-side and tracker-side signals for the shared tracker query arbiter.
// The slave modport is the arbiter; the master modport is the requesters/tracker environment.
interface signal_tracker_query_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int VALUE_WIDTH = 32
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*VALUE_WIDTH-1:0]  req_value;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0]              resp_valid;
  logic signed [VALUE_WIDTH-1:0]   resp_start;
  logic signed [VALUE_WIDTH-1:0]   resp_end;
  logic                            resp_timeout;
  logic                            busy;
  logic                            trk_recalculate_time;
  logic [VALUE_WIDTH-1:0]          trk_value_in;
  logic signed [VALUE_WIDTH-1:0]   trk_time_start;
  logic signed [VALUE_WIDTH-1:0]   trk_time_end;
  logic                            trk_data_valid;

  modport slave (
    input  req_valid, req_value, trk_time_start, trk_time_end, trk_data_valid,
    output req_ready, resp_valid, resp_start, resp_end, resp_timeout, busy,
           trk_recalculate_time, trk_value_in
  );

  modport master (
    output req_valid, req_value, trk_time_start, trk_time_end, trk_data_valid,
    input  req_ready, resp_valid, resp_start, resp_end, resp_timeout, busy,
           trk_recalculate_time, trk_value_in
  );
endinterface

// File: rtl/signal_tracker_query_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one signal-tracker query port,
// with a per-query timeout and a drain phase that waits out a lingering tracker result.
module signal_tracker_query_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  signal_tracker_query_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [PTR_W-1:0]              r_rr_ptr;
  logic [PTR_W-1:0]              r_owner;
  logic [PTR_W-1:0]              w_idx;
  logic [PTR_W-1:0]              w_win_idx;
  logic [PTR_W-1:0]              w_win_nxt_ptr;
  logic                          w_win_found;
  logic [NUM_REQ-1:0]            w_grant;
  logic                          w_accept;
  logic                          w_timeout_hit;
  logic [CNT_W-1:0]              r_cnt;
  logic [VALUE_WIDTH-1:0]        r_value;
  logic                          r_recalc;
  logic [NUM_REQ-1:0]            r_resp_valid;
  logic signed [VALUE_WIDTH-1:0] r_resp_start;
  logic signed [VALUE_WIDTH-1:0] r_resp_end;
  logic                          r_resp_timeout;

  // Search upward from the round-robin pointer; a stale tracker result blocks new grants.
  always_comb begin
    w_idx         = '0;
    w_win_idx     = '0;
    w_win_nxt_ptr = '0;
    w_win_found   = 1'b0;
    w_grant       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_win_found && bus.req_valid[w_idx]) begin
        w_win_found   = 1'b1;
        w_win_idx     = w_idx;
        w_win_nxt_ptr = PTR_W'((int'(w_idx) + 1) % NUM_REQ);
      end
    end
    if (r_state == IDLE && !bus.trk_data_valid && w_win_found) begin
      w_grant[w_win_idx] = 1'b1;
    end
  end

  assign w_accept      = |(bus.req_valid & w_grant);
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (bus.trk_data_valid || w_timeout_hit) w_state_nxt = DRAIN;
      DRAIN:   if (!bus.trk_data_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Real data is checked before the timeout so a result on the final ISSUE cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_cnt          <= '0;
      r_value        <= '0;
      r_recalc       <= 1'b0;
      r_resp_valid   <= '0;
      r_resp_start   <= '0;
      r_resp_end     <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner  <= w_win_idx;
            r_rr_ptr <= w_win_nxt_ptr;
            r_value  <= bus.req_value[w_win_idx*VALUE_WIDTH +: VALUE_WIDTH];
            r_recalc <= 1'b1;
            r_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (bus.trk_data_valid) begin
            r_resp_start   <= bus.trk_time_start;
            r_resp_end     <= bus.trk_time_end;
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= NUM_REQ'(1) << r_owner;
            r_recalc       <= 1'b0;
          end else if (w_timeout_hit) begin
            r_resp_start   <= '1;
            r_resp_end     <= '1;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= NUM_REQ'(1) << r_owner;
            r_recalc       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready            = w_grant;
  assign bus.resp_valid           = r_resp_valid;
  assign bus.resp_start           = r_resp_start;
  assign bus.resp_end             = r_resp_end;
  assign bus.resp_timeout         = r_resp_timeout;
  assign bus.busy                 = (r_state != IDLE);
  assign bus.trk_recalculate_time = r_recalc;
  assign bus.trk_value_in         = r_value;

endmodule

// File: doc/signal_tracker_query_arbiter.md
SIGNAL_TRACKER_QUERY_ARBITER -- requirements
Module: signal_tracker_query_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one tracker query port.
REQ-002 SHALL have parameter VALUE_WIDTH, default 32, width of cycles-back value and of each time result.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ISSUE cycles before a query is abandoned.
REQ-004 SHALL have ports:
 clk  in  1  sole clock, all logic on rising edge.
 rst_n  in  1  synchronous, active-low reset.
 req_valid  in  NUM_REQ  per-requester query request.
 req_value  in  NUM_REQ*VALUE_WIDTH  per-requester cycles-back value, requester i at slice i.
 req_ready  out  NUM_REQ  one-hot grant; acceptance = req_valid[i] && req_ready[i].
 resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the owning requester.
 resp_start  out  VALUE_WIDTH  signed start time of response.
 resp_end  out  VALUE_WIDTH  signed end time of response.
 resp_timeout  out  1  qualifies resp_valid; 1 = query abandoned.
 busy  out  1  high in any state other than IDLE.
 trk_recalculate_time  out  1  query strobe to tracker.
 trk_value_in  out  VALUE_WIDTH  cycles-back value to tracker.
 trk_time_start  in  VALUE_WIDTH  tracker result, start.
 trk_time_end  in  VALUE_WIDTH  tracker result, end.
 trk_data_valid  in  1  tracker result valid.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-006 SHALL, in IDLE with trk_data_valid=0, drive req_ready combinationally as one-hot round-robin winner among req_valid, searching from pointer rr_ptr upward with wrap; all zero if no req_valid.
REQ-007 SHALL, in IDLE with trk_data_valid=1 (stale result), drive req_ready=0 and remain in IDLE.
REQ-008 SHALL, on acceptance of requester i, latch owner=i and req_value slice i, set rr_ptr=(i+1) mod NUM_REQ, enter ISSUE next cycle.
REQ-009 SHALL drive req_ready=0 in ISSUE and DRAIN.
REQ-010 SHALL register trk_recalculate_time=1 and trk_value_in=latched value throughout ISSUE, first asserted the cycle after acceptance.
REQ-011 SHALL maintain a timeout counter cleared on ISSUE entry, incremented each ISSUE cycle.
REQ-012 SHALL, when trk_data_valid=1 is sampled in ISSUE, capture trk_time_start/trk_time_end into resp_start/resp_end, pulse resp_valid[owner] for exactly the next cycle with resp_timeout=0, deassert trk_recalculate_time that same next cycle, enter DRAIN.
REQ-013 SHALL, when the counter reaches TIMEOUT_CYCLES without trk_data_valid, set resp_start=resp_end=all-ones (-1), pulse resp_valid[owner] with resp_timeout=1, deassert trk_recalculate_time, enter DRAIN.
REQ-014 SHALL give trk_data_valid priority over timeout when both occur in the same cycle.
REQ-015 SHALL keep trk_recalculate_time=0 in DRAIN and return to IDLE the first cycle trk_data_valid=0 is sampled; DRAIN lasts at least one cycle.
REQ-016 SHALL hold resp_start/resp_end/resp_timeout stable from the pulse until the next response.
REQ-017 SHALL keep trk_value_in at last latched value outside ISSUE.
REQ-018 SHALL serve at most one outstanding query; request-to-response latency minimum 3 cycles (accept, ISSUE with data_valid, pulse).

Reset
REQ-019 SHALL, when rst_n=0 at a clock edge, force state=IDLE, rr_ptr=0, owner=0, counter=0, trk_recalculate_time=0, trk_value_in=0, resp_valid=0, resp_start=0, resp_end=0, resp_timeout=0, regardless of state.
REQ-020 SHALL not emit any resp_valid for a query interrupted by reset.
REQ-021 SHALL drive req_ready per REQ-006 in the first cycle after rst_n returns high.

Verification
REQ-022 Single query: req_valid[2]=1, value 3; tracker returns {5,7} two cycles into ISSUE -> resp_valid=4'b0100 once, resp_start=5, resp_end=7, resp_timeout=0.
REQ-023 Contention: req_valid=4'b1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0, each after prior DRAIN completes.
REQ-024 Timeout: tracker never asserts data_valid -> recalc high exactly 16 cycles, then resp_timeout=1, resp_start=resp_end=-1.
REQ-025 Coincidence: data_valid first seen on 16th ISSUE cycle -> real result reported, resp_timeout=0.
REQ-026 Drain: tracker holds data_valid 3 cycles after recalc drops -> DRAIN 3 cycles, req_ready=0 throughout, no re-issue.
REQ-027 Reset in ISSUE: rst_n=0 one cycle -> next cycle recalc=0, resp_valid=0, busy=0, rr_ptr=0.
